// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: latches decoded fields, forwards from EX/MEM and MEM/WB,
// detects load-use hazards and drives the ALU operands directly.
module alu_operand_stage #(
  parameter int unsigned                  DATA_WIDTH     = 32,
  parameter int unsigned                  REG_ADDR_WIDTH = 5,
  parameter int unsigned                  ALU_OP_WIDTH   = 4,
  parameter logic [ALU_OP_WIDTH-1:0]      BUBBLE_OP      = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [ALU_OP_WIDTH-1:0]   in_alu_op,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [DATA_WIDTH-1:0]     in_rs_data,
  input  logic [DATA_WIDTH-1:0]     in_rt_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic                      in_alu_src,
  input  logic                      in_reg_write,
  input  logic                      in_mem_read,
  input  logic                      hold,
  input  logic                      flush,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      load_use_stall,
  output logic                      ex_valid,
  output logic [ALU_OP_WIDTH-1:0]   ALUOperation,
  output logic [DATA_WIDTH-1:0]     A,
  output logic [DATA_WIDTH-1:0]     B,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read
);

  logic                      valid_q,     valid_d;
  logic [ALU_OP_WIDTH-1:0]   alu_op_q,    alu_op_d;
  logic [REG_ADDR_WIDTH-1:0] rs_addr_q,   rs_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rt_addr_q,   rt_addr_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
  logic [DATA_WIDTH-1:0]     rs_data_q,   rs_data_d;
  logic [DATA_WIDTH-1:0]     rt_data_q,   rt_data_d;
  logic [DATA_WIDTH-1:0]     imm_q,       imm_d;
  logic                      alu_src_q,   alu_src_d;
  logic                      reg_write_q, reg_write_d;
  logic                      mem_read_q,  mem_read_d;

  logic [DATA_WIDTH-1:0]     rs_fwd;
  logic [DATA_WIDTH-1:0]     rt_fwd;

  always_comb begin
    load_use_stall = valid_q & mem_read_q & (rd_addr_q != '0) & in_valid &
                     ((rd_addr_q == in_rs_addr) |
                      ((rd_addr_q == in_rt_addr) & ~in_alu_src)) &
                     ~hold & ~flush;
  end

  // load_use_stall is already masked by hold/flush, so flush and stall share
  // the bubble path and hold reduces to "don't capture".
  always_comb begin
    valid_d     = valid_q;
    alu_op_d    = alu_op_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rd_addr_d   = rd_addr_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (flush || load_use_stall) begin
      valid_d     = 1'b0;
      alu_op_d    = BUBBLE_OP;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rd_addr_d   = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (!hold) begin
      valid_d     = in_valid;
      alu_op_d    = in_alu_op;
      rs_addr_d   = in_rs_addr;
      rt_addr_d   = in_rt_addr;
      rd_addr_d   = in_rd_addr;
      rs_data_d   = in_rs_data;
      rt_data_d   = in_rt_data;
      imm_d       = in_imm;
      alu_src_d   = in_alu_src;
      reg_write_d = in_reg_write;
      mem_read_d  = in_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      alu_op_q    <= BUBBLE_OP;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_op_q    <= alu_op_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  // EX/MEM wins over MEM/WB; register 0 always reads the latched value.
  always_comb begin
    rs_fwd = rs_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_addr_q))
      rs_fwd = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_addr_q))
      rs_fwd = memwb_result;

    rt_fwd = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_addr_q))
      rt_fwd = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_addr_q))
      rt_fwd = memwb_result;
  end

  always_comb begin
    ex_valid      = valid_q;
    ALUOperation  = valid_q ? alu_op_q : BUBBLE_OP;
    A             = valid_q ? rs_fwd : '0;
    B             = valid_q ? (alu_src_q ? imm_q : rt_fwd) : '0;
    ex_store_data = valid_q ? rt_fwd : '0;
    ex_rd         = rd_addr_q;
    ex_reg_write  = valid_q & reg_write_q;
    ex_mem_read   = valid_q & mem_read_q;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a random
// run against a slot-level reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic        in_alu_src, in_reg_write, in_mem_read;
  logic        hold, flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        load_use_stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B, ex_store_data;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ALU_OP_WIDTH(4), .BUBBLE_OP(4'b0000)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_op(in_alu_op),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .hold(hold), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ALUOperation(ALUOperation),
    .A(A), .B(B), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction slot currently held in the stage.
  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        src, rw, mr;
  } slot_t;

  slot_t m;

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (a != 0 && exmem_reg_write && exmem_rd == a) return exmem_result;
    if (a != 0 && memwb_reg_write && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  function automatic logic exp_stall();
    return m.v && m.mr && m.rd != 0 && in_valid && !hold && !flush &&
           (m.rd == in_rs_addr || (m.rd == in_rt_addr && !in_alu_src));
  endfunction

  function automatic logic [3:0]  exp_op(); return m.v ? m.op : 4'b0000; endfunction
  function automatic logic [31:0] exp_a();  return m.v ? fwd(m.rs, m.rsd) : 32'd0; endfunction
  function automatic logic [31:0] exp_sd(); return m.v ? fwd(m.rt, m.rtd) : 32'd0; endfunction
  function automatic logic [31:0] exp_b();
    if (!m.v) return 32'd0;
    return m.src ? m.imm : fwd(m.rt, m.rtd);
  endfunction

  // Advance one clock; model applies reset > flush > hold > stall > capture.
  task automatic tick();
    slot_t nx;
    if (!reset || flush) nx = '0;
    else if (hold) nx = m;
    else if (exp_stall()) nx = '0;
    else begin
      nx.v = in_valid; nx.op = in_alu_op;
      nx.rs = in_rs_addr; nx.rt = in_rt_addr; nx.rd = in_rd_addr;
      nx.rsd = in_rs_data; nx.rtd = in_rt_data; nx.imm = in_imm;
      nx.src = in_alu_src; nx.rw = in_reg_write; nx.mr = in_mem_read;
    end
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                         input logic [31:0] rsd, rtd, imm,
                         input logic src, rw, mr);
    in_valid = 1'b1; in_alu_op = op;
    in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm;
    in_alu_src = src; in_reg_write = rw; in_mem_read = mr;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    hold = 0; flush = 0; clear_fwd();
    present(4'b0011, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 1'b0, 1'b1, 1'b1);
    reset = 0;
    tick(); tick();
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ex_valid); end
    checks++; if (ALUOperation !== 4'b0000) begin errors++; $display("FAIL reset_op: got %h exp 0", ALUOperation); end
    checks++; if (A !== 32'd0 || B !== 32'd0 || ex_store_data !== 32'd0) begin errors++;
      $display("FAIL reset_operands: got A=%h B=%h SD=%h exp 0", A, B, ex_store_data); end
    checks++; if (load_use_stall !== 1'b0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl: got stall=%b rd=%0d rw=%b mr=%b exp 0", load_use_stall, ex_rd, ex_reg_write, ex_mem_read); end
    reset = 1;
  endtask

  task automatic test_add();
    present(4'b0011, 5'd8, 5'd9, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0);
    exmem_reg_write = 1; exmem_rd = 5'd8; exmem_result = 32'd100;
    tick();
    checks++; if (A !== 32'd100) begin errors++; $display("FAIL add_A: got %0d exp 100", A); end
    checks++; if (B !== 32'd7) begin errors++; $display("FAIL add_B: got %0d exp 7", B); end
    checks++; if (ALUOperation !== 4'b0011 || ex_valid !== 1'b1) begin errors++;
      $display("FAIL add_op: got op=%h v=%b exp 3/1", ALUOperation, ex_valid); end
    checks++; if (ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin errors++;
      $display("FAIL add_rd: got rd=%0d rw=%b exp 3/1", ex_rd, ex_reg_write); end
  endtask

  task automatic test_double_hazard();
    present(4'b0010, 5'd10, 5'd4, 5'd6, 32'h55, 32'h44, 32'd0, 1'b0, 1'b1, 1'b0);
    exmem_reg_write = 1; exmem_rd = 5'd10; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 5'd10; memwb_result = 32'h22;
    tick();
    checks++; if (A !== 32'h11) begin errors++; $display("FAIL dbl_exmem: got %h exp 11", A); end
    exmem_reg_write = 0; #1;
    checks++; if (A !== 32'h22) begin errors++; $display("FAIL dbl_memwb: got %h exp 22", A); end
    memwb_reg_write = 0; #1;
    checks++; if (A !== 32'h55) begin errors++; $display("FAIL dbl_none: got %h exp 55", A); end
    present(4'b0010, 5'd0, 5'd0, 5'd6, 32'h77, 32'h66, 32'd0, 1'b0, 1'b1, 1'b0);
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBB;
    tick();
    checks++; if (A !== 32'h77 || ex_store_data !== 32'h66) begin errors++;
      $display("FAIL dbl_r0: got A=%h SD=%h exp 77/66", A, ex_store_data); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    present(4'b0010, 5'd1, 5'd2, 5'd12, 32'h10, 32'h20, 32'h4, 1'b1, 1'b1, 1'b1);
    tick();
    present(4'b0110, 5'd12, 5'd3, 5'd7, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", load_use_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || load_use_stall !== 1'b0 || ALUOperation !== 4'b0000) begin errors++;
      $display("FAIL lu_bubble: got v=%b stall=%b op=%h exp 0/0/0", ex_valid, load_use_stall, ALUOperation); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ALUOperation !== 4'b0110 || ex_rd !== 5'd7) begin errors++;
      $display("FAIL lu_recapture: got v=%b op=%h rd=%0d exp 1/6/7", ex_valid, ALUOperation, ex_rd); end
    present(4'b0010, 5'd1, 5'd2, 5'd12, 32'h10, 32'h20, 32'h4, 1'b1, 1'b1, 1'b1);
    tick();
    present(4'b0001, 5'd5, 5'd12, 5'd9, 32'h3, 32'h4, 32'h99, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_imm_nostall: got %b exp 0", load_use_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || B !== 32'h99) begin errors++;
      $display("FAIL lu_imm_capture: got v=%b B=%h exp 1/99", ex_valid, B); end
  endtask

  task automatic test_hold();
    present(4'b0101, 5'd3, 5'd4, 5'd5, 32'hA1, 32'hB2, 32'hC3, 1'b0, 1'b1, 1'b0);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      present(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++; if (ALUOperation !== 4'b0101 || A !== 32'hA1 || B !== 32'hB2 || ex_rd !== 5'd5) begin errors++;
        $display("FAIL hold_frozen: got op=%h A=%h B=%h rd=%0d exp 5/a1/b2/5", ALUOperation, A, B, ex_rd); end
    end
    flush = 1;
    tick();
    checks++; if (ex_valid !== 1'b0 || A !== 32'd0 || ex_reg_write !== 1'b0) begin errors++;
      $display("FAIL hold_flush: got v=%b A=%h rw=%b exp 0/0/0", ex_valid, A, ex_reg_write); end
    hold = 0; flush = 0;
  endtask

  task automatic test_reset_midstream();
    present(4'b0010, 5'd1, 5'd2, 5'd12, 32'h10, 32'h20, 32'h4, 1'b1, 1'b1, 1'b1);
    tick();
    present(4'b0110, 5'd12, 5'd3, 5'd7, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %b exp 1", load_use_stall); end
    hold = 1; reset = 0;
    tick();
    checks++; if (ex_valid !== 1'b0 || ALUOperation !== 4'b0000 || A !== 32'd0 || B !== 32'd0 ||
                  ex_store_data !== 32'd0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0 ||
                  ex_mem_read !== 1'b0 || load_use_stall !== 1'b0) begin errors++;
      $display("FAIL mid_reset: got v=%b op=%h A=%h B=%h SD=%h rd=%0d rw=%b mr=%b st=%b exp all 0",
               ex_valid, ALUOperation, A, B, ex_store_data, ex_rd, ex_reg_write, ex_mem_read, load_use_stall); end
    reset = 1; hold = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 7) != 0);
      present(4'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
      in_valid = ($urandom_range(0, 7) != 0);
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      #1;
      checks++; if (load_use_stall !== exp_stall()) begin errors++;
        $display("FAIL rnd_stall[%0d]: got %b exp %b", i, load_use_stall, exp_stall()); end
      checks++; if (ex_valid !== m.v || ALUOperation !== exp_op()) begin errors++;
        $display("FAIL rnd_op[%0d]: got v=%b op=%h exp %b/%h", i, ex_valid, ALUOperation, m.v, exp_op()); end
      checks++; if (A !== exp_a()) begin errors++; $display("FAIL rnd_A[%0d]: got %h exp %h", i, A, exp_a()); end
      checks++; if (B !== exp_b()) begin errors++; $display("FAIL rnd_B[%0d]: got %h exp %h", i, B, exp_b()); end
      checks++; if (ex_store_data !== exp_sd()) begin errors++;
        $display("FAIL rnd_sd[%0d]: got %h exp %h", i, ex_store_data, exp_sd()); end
      checks++; if (ex_rd !== m.rd || ex_reg_write !== (m.v & m.rw) || ex_mem_read !== (m.v & m.mr)) begin errors++;
        $display("FAIL rnd_ctrl[%0d]: got rd=%0d rw=%b mr=%b exp %0d/%b/%b", i, ex_rd, ex_reg_write, ex_mem_read,
                 m.rd, m.v & m.rw, m.v & m.mr); end
      tick();
    end
    hold = 0; flush = 0; clear_fwd();
  endtask

  initial begin
    m = '0;
    reset = 0; hold = 0; flush = 0; clear_fwd();
    in_valid = 0; in_alu_op = 0; in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
    in_rs_data = 0; in_rt_data = 0; in_imm = 0;
    in_alu_src = 0; in_reg_write = 0; in_mem_read = 0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_double_hazard();
    test_load_use();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
